// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and helpers: lane packing defaults and the
// constant clog2 used to size select ports.
package fft_pkg;

    localparam int unsigned LANE_W    = 16;
    localparam int unsigned NUM_LANES = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One {valid, data} stage of the delay line: shifts on en, clears on flush,
// clears asynchronously on rst_n.
module delay_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (en) begin
            valid_d = d_valid;
            data_d  = d_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign q_valid = valid_q;
    assign q_data  = data_q;

endmodule

// File: rtl/param_delay_line.sv
// Multi-lane delay line with runtime-selectable depth, stall, flush and a
// primed flag that marks when the output carries fully-delayed input.
module param_delay_line
    import fft_pkg::*;
#(
    parameter  int unsigned WIDTH      = LANE_W,
    parameter  int unsigned CHANNELS   = NUM_LANES,
    parameter  int unsigned MAX_CYCLES = 8,
    localparam int unsigned DW         = clog2(MAX_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      flush,
    input  logic [DW-1:0]             delay,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      primed
);

    localparam int unsigned BUS_W = CHANNELS * WIDTH;
    localparam logic [DW-1:0] MaxD = DW'(MAX_CYCLES);

    logic             stage_valid [MAX_CYCLES];
    logic [BUS_W-1:0] stage_data  [MAX_CYCLES];

    logic [DW-1:0] d_eff;
    logic [DW-1:0] delay_d, delay_q;
    logic [DW-1:0] prime_cnt_d, prime_cnt_q;
    logic          delay_changed;

    for (genvar i = 0; i < int'(MAX_CYCLES); i++) begin : g_stage
        if (i == 0) begin : g_head
            delay_stage #(
                .WIDTH (BUS_W)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en),
                .flush   (flush),
                .d_valid (in_valid),
                .d_data  (in_data),
                .q_valid (stage_valid[i]),
                .q_data  (stage_data[i])
            );
        end else begin : g_tail
            delay_stage #(
                .WIDTH (BUS_W)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en),
                .flush   (flush),
                .d_valid (stage_valid[i-1]),
                .d_data  (stage_data[i-1]),
                .q_valid (stage_valid[i]),
                .q_data  (stage_data[i])
            );
        end
    end

    always_comb begin
        if (delay == '0) begin
            d_eff = DW'(1);
        end else if (delay > MaxD) begin
            d_eff = MaxD;
        end else begin
            d_eff = delay;
        end
    end

    // Compare-based tap select keeps out-of-range indices unreachable.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        for (int i = 0; i < int'(MAX_CYCLES); i++) begin
            if (d_eff == DW'(i + 1)) begin
                out_valid = stage_valid[i];
                out_data  = stage_data[i];
            end
        end
    end

    assign delay_changed = (d_eff != delay_q);
    assign delay_d       = d_eff;

    always_comb begin
        prime_cnt_d = prime_cnt_q;
        if (flush || delay_changed) begin
            prime_cnt_d = '0;
        end else if (en && (prime_cnt_q < d_eff)) begin
            prime_cnt_d = prime_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_q     <= '0;
            prime_cnt_q <= '0;
        end else begin
            delay_q     <= delay_d;
            prime_cnt_q <= prime_cnt_d;
        end
    end

    assign primed = (prime_cnt_q >= d_eff) && !delay_changed;

endmodule

// File: tb/tb_param_delay_line.sv
// Self-checking bench for param_delay_line: directed tables and sequences
// plus randomized traffic checked against a queue-based reference model.
module tb_param_delay_line;

    localparam int W   = 16;
    localparam int CH  = 2;
    localparam int MAX = 8;
    localparam int BW  = W * CH;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          flush;
    logic [3:0]    delay;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic          primed;

    int n_checks = 0;
    int n_fail   = 0;

    param_delay_line #(
        .WIDTH      (W),
        .CHANNELS   (CH),
        .MAX_CYCLES (MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .delay     (delay),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .primed    (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: history of accepted samples, newest first.
    typedef struct packed {
        logic          v;
        logic [BW-1:0] d;
    } smp_t;

    smp_t hist[$];
    int   m_cnt;
    int   m_prev;

    function automatic int clampd(input int d);
        if (d == 0) return 1;
        if (d > MAX) return MAX;
        return d;
    endfunction

    function automatic logic [BW-1:0] ramp(input int k);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'(k);
        hi = 16'(32'h100 + k);
        return {hi, lo};
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int i = 0; i < MAX; i++) hist.push_back('0);
    endtask

    task automatic model_reset();
        model_clear();
        m_cnt  = 0;
        m_prev = 0;
    endtask

    task automatic model_edge(input logic e, input logic f, input int d, input logic v,
                              input logic [BW-1:0] x);
        int   deff;
        smp_t s;
        deff = clampd(d);
        if (f) begin
            model_clear();
        end else if (e) begin
            s.v = v;
            s.d = x;
            hist.push_front(s);
            void'(hist.pop_back());
        end
        if (f || deff != m_prev) m_cnt = 0;
        else if (e && m_cnt < deff) m_cnt++;
        m_prev = deff;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int   deff;
        smp_t e;
        deff = clampd(int'(delay));
        e    = hist[deff-1];
        check("mdl_out_valid", 64'(out_valid), 64'(e.v));
        check("mdl_out_data", 64'(out_data), 64'(e.d));
        check("mdl_primed", 64'(primed), 64'((m_cnt >= deff) && (deff == m_prev)));
    endtask

    // Apply one cycle of inputs, clock it, then compare #1 after the edge.
    task automatic step(input logic e, input logic f, input int d, input logic v,
                        input logic [BW-1:0] x);
        en       = e;
        flush    = f;
        delay    = 4'(d);
        in_valid = v;
        in_data  = x;
        @(posedge clk);
        model_edge(e, f, d, v, x);
        #1;
        check_model();
    endtask

    typedef struct {
        int dly;
        int lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int k;
        int j;
        int edges;
        int d_r;
        logic e_r;

        vecs[0] = '{dly: 0,  lat: 1};
        vecs[1] = '{dly: 1,  lat: 1};
        vecs[2] = '{dly: 3,  lat: 3};
        vecs[3] = '{dly: 5,  lat: 5};
        vecs[4] = '{dly: 9,  lat: 8};
        vecs[5] = '{dly: 15, lat: 8};

        rst_n = 1'b0; en = 1'b0; flush = 1'b0; delay = '0; in_valid = 1'b0; in_data = '0;
        model_reset();
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_primed", 64'(primed), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill with 0xAAAA, then assert reset between edges.
        for (int i = 0; i < MAX; i++) step(1'b1, 1'b0, 8, 1'b1, 32'hAAAA_AAAA);
        check("fill_out_data", 64'(out_data), 64'hAAAA_AAAA);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", 64'(out_data), 64'd0);
        check("async_rst_primed", 64'(primed), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // delay=0 behaves as delay=1.
        step(1'b1, 1'b0, 0, 1'b1, 32'h00C0_FFEE);
        check("clamp0_data", 64'(out_data), 64'h00C0_FFEE);
        check("clamp0_valid", 64'(out_valid), 64'd1);
        check("clamp0_primed_chg", 64'(primed), 64'd0);
        step(1'b1, 1'b0, 0, 1'b1, 32'h0BAD_F00D);
        check("clamp0_data2", 64'(out_data), 64'h0BAD_F00D);
        check("clamp0_primed", 64'(primed), 64'd1);

        // Table: latency per requested delay, flush taken together with en.
        for (int t = 0; t < 6; t++) begin
            step(1'b0, 1'b0, vecs[t].dly, 1'b0, '0);
            step(1'b0, 1'b0, vecs[t].dly, 1'b0, '0);
            step(1'b1, 1'b1, vecs[t].dly, 1'b1, 32'h1234_1234);
            check("tbl_flush_valid", 64'(out_valid), 64'd0);
            check("tbl_flush_primed", 64'(primed), 64'd0);
            for (int i = 0; i < vecs[t].lat + 2; i++) begin
                step(1'b1, 1'b0, vecs[t].dly, 1'b1, ramp(i));
                edges = i + 1;
                check("tbl_primed", 64'(primed), 64'(edges >= vecs[t].lat));
                check("tbl_valid", 64'(out_valid), 64'(edges >= vecs[t].lat));
                check("tbl_data", 64'(out_data),
                      (edges >= vecs[t].lat) ? 64'(ramp(edges - vecs[t].lat)) : 64'd0);
            end
        end

        // Stall: en low for 4 cycles mid-ramp at delay 3.
        step(1'b1, 1'b1, 3, 1'b0, '0);
        k = 0;
        for (int c = 0; c < 15; c++) begin
            e_r = !(c >= 5 && c < 9);
            step(e_r, 1'b0, 3, 1'b1, ramp(k));
            if (e_r) k++;
            check("stall_valid", 64'(out_valid), 64'(k >= 3));
            check("stall_primed", 64'(primed), 64'(k >= 3));
            check("stall_data", 64'(out_data), (k >= 3) ? 64'(ramp(k - 3)) : 64'd0);
        end

        // Delay change 2 -> 6 after 20 enabled cycles.
        step(1'b1, 1'b1, 2, 1'b0, '0);
        k = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 1'b0, 2, 1'b1, ramp(k));
            k++;
        end
        check("dchg_primed_before", 64'(primed), 64'd1);
        delay = 4'd6;
        #1;
        check("dchg_primed_comb", 64'(primed), 64'd0);
        for (j = 1; j <= 10; j++) begin
            step(1'b1, 1'b0, 6, 1'b1, ramp(k));
            k++;
            check("dchg_primed", 64'(primed), 64'(j >= 7));
            if (j >= 7) check("dchg_data", 64'(out_data), 64'(ramp(k - 6)));
        end

        // Random traffic against the model.
        d_r = 4;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) == 0) d_r = int'($urandom_range(0, 15));
            step($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, d_r,
                 1'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
